// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage: registered valid/ready handshake on both sides,
// with a head (main) entry feeding the output and a skid entry absorbing one beat of backpressure.
module pipe_skid_stage #(
    parameter int WIDTH      = 32,
    parameter bit ZERO_EMPTY = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam logic [WIDTH-1:0] ZERO_DATA = {WIDTH{1'b0}};

    logic             main_valid_r;
    logic [WIDTH-1:0] main_data_r;
    logic             skid_valid_r;
    logic [WIDTH-1:0] skid_data_r;
    logic [1:0]       occupancy_r;
    logic             in_ready_r;

    logic             main_valid_nxt_s;
    logic [WIDTH-1:0] main_data_nxt_s;
    logic             skid_valid_nxt_s;
    logic [WIDTH-1:0] skid_data_nxt_s;
    logic [1:0]       occupancy_nxt_s;
    logic             in_ready_nxt_s;

    logic             in_fire_s;
    logic             out_fire_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = main_valid_r & out_ready;

    // Next-state for both entries; flush wins over every transfer.
    always_comb begin
        main_valid_nxt_s = main_valid_r;
        main_data_nxt_s  = main_data_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_data_nxt_s  = skid_data_r;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
            if (ZERO_EMPTY) begin
                main_data_nxt_s = ZERO_DATA;
                skid_data_nxt_s = ZERO_DATA;
            end else begin
                main_data_nxt_s = main_data_r;
                skid_data_nxt_s = skid_data_r;
            end
        end else if (skid_valid_r) begin
            // in_ready is low here, so only the drain of main can happen
            if (out_fire_s) begin
                main_data_nxt_s  = skid_data_r;
                skid_valid_nxt_s = 1'b0;
                if (ZERO_EMPTY) begin
                    skid_data_nxt_s = ZERO_DATA;
                end else begin
                    skid_data_nxt_s = skid_data_r;
                end
            end else begin
                skid_valid_nxt_s = 1'b1;
            end
        end else if (main_valid_r) begin
            case ({out_fire_s, in_fire_s})
                2'b11: begin
                    main_data_nxt_s = in_data;
                end
                2'b10: begin
                    main_valid_nxt_s = 1'b0;
                    if (ZERO_EMPTY) begin
                        main_data_nxt_s = ZERO_DATA;
                    end else begin
                        main_data_nxt_s = main_data_r;
                    end
                end
                2'b01: begin
                    skid_valid_nxt_s = 1'b1;
                    skid_data_nxt_s  = in_data;
                end
                default: begin
                    main_valid_nxt_s = 1'b1;
                end
            endcase
        end else begin
            if (in_fire_s) begin
                main_valid_nxt_s = 1'b1;
                main_data_nxt_s  = in_data;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end
    end

    // Derived registered flags, computed from the next valid bits so they never lag.
    always_comb begin
        in_ready_nxt_s  = ~skid_valid_nxt_s;
        occupancy_nxt_s = {1'b0, main_valid_nxt_s} + {1'b0, skid_valid_nxt_s};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_r <= 1'b0;
            main_data_r  <= ZERO_DATA;
            skid_valid_r <= 1'b0;
            skid_data_r  <= ZERO_DATA;
            occupancy_r  <= 2'd0;
            in_ready_r   <= 1'b1;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            main_data_r  <= main_data_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
            occupancy_r  <= occupancy_nxt_s;
            in_ready_r   <= in_ready_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;
    assign occupancy = occupancy_r;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scenario-driven bench for pipe_skid_stage with a queue scoreboard of accepted beats.
module tb_pipe_skid_stage;

    localparam int WIDTH      = 32;
    localparam bit ZERO_EMPTY = 1'b1;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];
    bit last_in_fire = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(WIDTH), .ZERO_EMPTY(ZERO_EMPTY)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    // Advance one clock; the model decides fires from its own occupancy, not the DUT's.
    task automatic cycle();
        bit in_f;
        bit out_f;
        logic [WIDTH-1:0] tmp;
        in_f  = in_valid && (exp_q.size() < 2);
        out_f = out_ready && (exp_q.size() > 0);
        last_in_fire = in_f;
        @(posedge clk);
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            if (out_f) tmp = exp_q.pop_front();
            if (in_f) exp_q.push_back(in_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
        cycle();
        cycle();
        total++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b1 ^ 1'b1, 1'b1, 2'd0, 32'h0}) begin
            bad++;
            $display("FAIL reset: got v=%b rdy=%b occ=%0d data=%0h want v=0 rdy=1 occ=0 data=0",
                     out_valid, in_ready, occupancy, out_data);
        end
        reset = 1'b0; in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_streaming();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = i;
            cycle();
            total++;
            if ({out_valid, in_ready, occupancy, out_data} !== {1'b1, 1'b1, 2'd1, 32'(i)}) begin
                bad++;
                $display("FAIL stream[%0d]: got v=%b rdy=%b occ=%0d data=%0h want v=1 rdy=1 occ=1 data=%0h",
                         i, out_valid, in_ready, occupancy, out_data, i);
            end
        end
        in_valid = 1'b0;
        cycle();
        total++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            bad++;
            $display("FAIL stream_drain: got v=%b rdy=%b occ=%0d data=%0h want v=0 rdy=1 occ=0 data=0",
                     out_valid, in_ready, occupancy, out_data);
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA; cycle();
        in_data = 32'hB; cycle();
        in_data = 32'hD;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({out_valid, in_ready, occupancy, out_data} !== {1'b1, 1'b0, 2'd2, 32'hA}) begin
                bad++;
                $display("FAIL skid_full[%0d]: got v=%b rdy=%b occ=%0d data=%0h want v=1 rdy=0 occ=2 data=a",
                         k, out_valid, in_ready, occupancy, out_data);
            end
            if (k == 0) cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        total++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b1, 1'b1, 2'd1, 32'hB}) begin
            bad++;
            $display("FAIL skid_drain1: got v=%b rdy=%b occ=%0d data=%0h want v=1 rdy=1 occ=1 data=b",
                     out_valid, in_ready, occupancy, out_data);
        end
        cycle();
        total++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            bad++;
            $display("FAIL skid_drain2: got v=%b rdy=%b occ=%0d data=%0h want v=0 rdy=1 occ=0 data=0",
                     out_valid, in_ready, occupancy, out_data);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h1; cycle();
        in_data = 32'h2; cycle();
        flush = 1'b1; in_data = 32'hC;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        total++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            bad++;
            $display("FAIL flush_full: got v=%b rdy=%b occ=%0d data=%0h want v=0 rdy=1 occ=0 data=0",
                     out_valid, in_ready, occupancy, out_data);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_leak[%0d]: got v=%b data=%0h want v=0", k, out_valid, out_data);
            end
        end
        // flush in the same cycle as an output fire and an input fire
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7; cycle();
        out_ready = 1'b1; flush = 1'b1; in_data = 32'h8; cycle();
        flush = 1'b0; in_valid = 1'b0;
        total++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            bad++;
            $display("FAIL flush_fire: got v=%b rdy=%b occ=%0d data=%0h want v=0 rdy=1 occ=0 data=0",
                     out_valid, in_ready, occupancy, out_data);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h3; cycle();
        in_data = 32'h4; cycle();
        reset = 1'b1; in_data = 32'h9;
        cycle();
        reset = 1'b0;
        total++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            bad++;
            $display("FAIL reset_mid: got v=%b rdy=%b occ=%0d data=%0h want v=0 rdy=1 occ=0 data=0",
                     out_valid, in_ready, occupancy, out_data);
        end
        in_data = 32'h5; cycle();
        in_valid = 1'b0;
        total++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b1, 1'b1, 2'd1, 32'h5}) begin
            bad++;
            $display("FAIL reset_first: got v=%b rdy=%b occ=%0d data=%0h want v=1 rdy=1 occ=1 data=5",
                     out_valid, in_ready, occupancy, out_data);
        end
        out_ready = 1'b1; cycle();
        total++;
        if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
            bad++;
            $display("FAIL reset_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_random();
        bit hold_pending = 1'b0;
        logic [WIDTH-1:0] hold_data = '0;
        in_valid = 1'b0;
        last_in_fire = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if (!(in_valid && !last_in_fire)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            total++;
            if (occupancy > 2'd2 || occupancy !== 2'(exp_q.size()) || out_valid !== (exp_q.size() != 0)) begin
                bad++;
                $display("FAIL rand_occ[%0d]: got occ=%0d v=%b want occ=%0d", n, occupancy, out_valid, exp_q.size());
            end
            if (out_ready && exp_q.size() > 0) begin
                total++;
                if (out_data !== exp_q[0]) begin
                    bad++;
                    $display("FAIL rand_data[%0d]: got %0h want %0h", n, out_data, exp_q[0]);
                end
            end
            if (hold_pending) begin
                total++;
                if (out_data !== hold_data) begin
                    bad++;
                    $display("FAIL rand_stable[%0d]: got %0h want %0h", n, out_data, hold_data);
                end
            end
            hold_pending = (exp_q.size() > 0) && !out_ready;
            hold_data    = out_data;
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle(); cycle();
        total++;
        if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
            bad++;
            $display("FAIL rand_final: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
